load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit for the RV64I core. It sits between execute and write-back. It accepts one LOAD/STORE request, carrying the computed effective address, from the core's state machine. It drives a 32-bit-word synchronous memory port, doing one beat for B/H/W accesses and two beats for D. It returns an aligned, sign- or zero-extended 64-bit load result, or an error, for register write-back.

## Interface
- MEM_AW, 12, memory word-address width (4096 words)
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_store  in  1  1 = STORE, 0 = LOAD
- req_funct3  in  3  instruction funct3 (width/sign)
- req_addr  in  64  effective byte address rs1+imm
- req_wdata  in  64  rs2 store data
- req_rd  in  5  destination register
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write when mem_en
- mem_wmask  out  4  byte-lane write enables
- mem_addr  out  MEM_AW  word index
- mem_wdata  out  32  write data, lane-replicated
- mem_rdata  in  32  read data, valid the cycle after a read (mem_en & !mem_we)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd  out  5  rd of completed request (0 for stores)
- rsp_data  out  64  load result (0 for stores/errors)
- rsp_err  out  1  misaligned or illegal funct3

## Operation
- States: IDLE, RD0, RD1, CAP, ST0, ST1, RESP. req_ready = (state==IDLE).
- Accept on req_valid & req_ready; register store, funct3, addr, wdata, rd. Inputs are ignored in all other states.
- Decode at accept:
  - illegal = load funct3==3'b111, or store funct3[2]==1.
  - misaligned = H & addr[0], W & addr[1:0]!=0, D & addr[2:0]!=0.
  - On either: IDLE->RESP with err=1 and no memory access.
- Word index w0 = addr[MEM_AW+1:2]; upper address bits are ignored. w1 = w0+1, mod 2^MEM_AW (wraps at top).
- Load B/H/W: IDLE->RD0 (read w0) ->CAP (capture rdata) ->RESP.
- Load D: IDLE->RD0 (read w0) ->RD1 (read w1, capture w0) ->CAP (capture w1) ->RESP. Result is {w1,w0}.
- Load extract:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended to 64.
  - LH/LHU: half lane addr[1], sign- or zero-extended.
  - LW: sign-extended. LWU: zero-extended.
- Store B/H/W: IDLE->ST0 ->RESP. Store D: IDLE->ST0 (w0, low 32) ->ST1 (w1, high 32) ->RESP.
- Store lanes:
  - SB: mask = 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011<<{addr[1],1'b0}, data = {2{wdata[15:0]}}.
  - SW/SD: mask = 4'b1111.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- rsp_rd/rsp_data/rsp_err are registered and hold their values until the next RESP.
- mem_en is asserted only in RD0, RD1, ST0, ST1. mem_we is asserted only in ST0 and ST1. mem_wmask is 0 when !mem_we.

## Timing
- Cycle 0 = accept edge. Cycles to rsp_valid: error 1, SB/SH/SW 2, SD 3, LB..LWU 3, LD 4.
- req_ready rises the cycle after rsp_valid, giving back-to-back issue with one idle cycle per request.
- Reset values: state IDLE, req_ready 1, all other outputs 0.
- Reset mid-operation:
  - Next cycle is IDLE, with no further mem_en and no rsp_valid.
  - A second beat of SD in flight is dropped, leaving a partial store (accepted).
- A read returning in the same cycle as reset is discarded.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B/H/W/D/BU/HU/WU.
  - state enum lsu_state_t.
  - width-decode function returning byte count.
- Sub-module load_align is combinational: (funct3, addr[1:0], word) -> 64-bit extended result. It is used at CAP for non-D loads.
- Top holds the FSM, request registers, store lane formatting and response registers.

## Test plan
- MEM[0]=0x8765_43F1; LB addr 0x8000_0000 -> rsp_data 0xFFFF_FFFF_FFFF_FFF1, rd echoed, 3 cycles. LBU addr +3 -> 0x87.
- MEM[2]=0x1122_3344, MEM[3]=0xAABB_CCDD; LD addr 0x8000_0008 -> 0xAABB_CCDD_1122_3344, 4 cycles, mem_addr 2 then 3.
- SH wdata 0xBEEF addr 0x8000_0006 -> mem_wmask 4'b1100, mem_wdata 0xBEEF_BEEF, mem_addr 1; rsp_err 0 at cycle 2.
- SD 0x0123_4567_89AB_CDEF at word index 4095 -> beat0 idx 4095 data 0x89AB_CDEF, beat1 idx 0 data 0x0123_4567.
- LW addr 0x8000_0002, then SD with funct3 3'b111 -> each rsp_err=1 at cycle 1, no mem_en, rsp_data 0.
- Assert reset during RD1 of an LD -> next cycle IDLE, req_ready 1, no rsp_valid, mem_en 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the RV64I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CAP,
    ST0,
    ST1,
    RESP
  } lsu_state_t;

  // Access size in bytes; the sign bit of funct3 does not affect width.
  function automatic logic [3:0] accessBytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory-port and response bundle of the load/store unit.
interface load_store_unit_if #(parameter int MEM_AW = 12) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_wmask;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic [4:0]        rsp_rd;
  logic [63:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
    input  mem_rdata,
    output rsp_valid, rsp_rd, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
    output mem_rdata,
    input  rsp_valid, rsp_rd, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Extracts and sign/zero-extends a B/H/W load from one 32-bit memory word.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOff,
  input  logic [31:0] word,
  output logic [63:0] result
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = word[{byteOff, 3'b000} +: 8];
    laneHalf = byteOff[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (funct3)
      F3_B:    result = {{56{laneByte[7]}}, laneByte};
      F3_BU:   result = {56'd0, laneByte};
      F3_H:    result = {{48{laneHalf[15]}}, laneHalf};
      F3_HU:   result = {48'd0, laneHalf};
      F3_W:    result = {{32{word[31]}}, word};
      F3_WU:   result = {32'd0, word};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV64I load/store unit: one request at a time, 32-bit memory
// port, one beat for B/H/W and two beats for D.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic clk,
  input  logic reset,
  load_store_unit_if.slave bus
);

  lsu_state_t        state, nextState;
  logic              rStore;
  logic [2:0]        rF3;
  logic [MEM_AW+1:0] rAddr;
  logic [63:0]       rWdata;
  logic [4:0]        rRd;
  logic [31:0]       lowWord;

  logic [4:0]        rspRd;
  logic [63:0]       rspData;
  logic              rspErr;

  logic              accept, illegal, misaligned, rIsD;
  logic [3:0]        reqBytes;
  logic [MEM_AW-1:0] w0, w1;
  logic [3:0]        storeMask;
  logic [31:0]       storeLo;
  logic [63:0]       alignOut;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign rIsD          = (rF3[1:0] == 2'b11);
  assign w0            = rAddr[MEM_AW+1:2];
  assign w1            = w0 + MEM_AW'(1);

  always_comb begin
    reqBytes   = accessBytes(bus.req_funct3);
    illegal    = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    misaligned = (({1'b0, bus.req_addr[2:0]} & (reqBytes - 4'd1)) != 4'd0);
  end

  load_align u_align (
    .funct3  (rF3),
    .byteOff (rAddr[1:0]),
    .word    (bus.mem_rdata),
    .result  (alignOut)
  );

  always_comb begin
    case (rF3[1:0])
      2'b00: begin
        storeMask = 4'b0001 << rAddr[1:0];
        storeLo   = {4{rWdata[7:0]}};
      end
      2'b01: begin
        storeMask = 4'b0011 << {rAddr[1], 1'b0};
        storeLo   = {2{rWdata[15:0]}};
      end
      default: begin
        storeMask = 4'b1111;
        storeLo   = rWdata[31:0];
      end
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) begin
        if (illegal | misaligned) nextState = RESP;
        else if (bus.req_store)   nextState = ST0;
        else                      nextState = RD0;
      end
      RD0:     nextState = rIsD ? RD1 : CAP;
      RD1:     nextState = CAP;
      CAP:     nextState = RESP;
      ST0:     nextState = rIsD ? ST1 : RESP;
      ST1:     nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wmask = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rsp_valid = (state == RESP);
    case (state)
      RD0: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = w0;
      end
      RD1: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = w1;
      end
      ST0: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w0;
        bus.mem_wmask = storeMask;
        bus.mem_wdata = storeLo;
      end
      ST1: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w1;
        bus.mem_wmask = 4'b1111;
        bus.mem_wdata = rWdata[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Response fields only change on the transition into RESP, so they hold
  // the last completion while the next request is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rStore  <= 1'b0;
      rF3     <= '0;
      rAddr   <= '0;
      rWdata  <= '0;
      rRd     <= '0;
      lowWord <= '0;
      rspRd   <= '0;
      rspData <= '0;
      rspErr  <= 1'b0;
    end else begin
      if (accept) begin
        rStore <= bus.req_store;
        rF3    <= bus.req_funct3;
        rAddr  <= bus.req_addr[MEM_AW+1:0];
        rWdata <= bus.req_wdata;
        rRd    <= bus.req_rd;
        if (illegal | misaligned) begin
          rspRd   <= bus.req_store ? 5'd0 : bus.req_rd;
          rspData <= '0;
          rspErr  <= 1'b1;
        end
      end
      case (state)
        RD1: lowWord <= bus.mem_rdata;
        CAP: begin
          rspRd   <= rRd;
          rspData <= rIsD ? {bus.mem_rdata, lowWord} : alignOut;
          rspErr  <= 1'b0;
        end
        ST0, ST1: if (nextState == RESP) begin
          rspRd   <= rStore ? 5'd0 : rRd;
          rspData <= '0;
          rspErr  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_rd   = rspRd;
  assign bus.rsp_data = rspData;
  assign bus.rsp_err  = rspErr;

endmodule
